// File: rtl/gemm_stream_controller_if.sv
// Activation-in and result-out valid/ready streams of the GEMM sequencer.
// Ports: in_valid/in_ready/in_data (feeder -> ctrl), res_* (ctrl -> sink).
interface gemm_stream_controller_if #(
    parameter int SA_SIZE                = 2,
    parameter int WEIGHT_ACTIVATION_SIZE = 8
);
    logic                                                in_valid;
    logic                                                in_ready;
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] in_data;
    logic                                                res_valid;
    logic                                                res_ready;
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] res_data;
    logic                                                res_last;

    // controller side
    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data, res_last
    );

    // feeder / result sink side
    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data, res_last
    );
endinterface

// File: rtl/gemm_stream_controller.sv
// Job sequencer for a fixed-weight systolic array: feeds activation vectors,
// tags real results vs bubbles, flushes at job end, returns results.
// Ports: clk, resetn, start, num_vectors, busy, done, bus (streams),
//        sa_advance, sa_inputs, sa_outputs (array side).
module gemm_stream_controller #(
    parameter int SA_SIZE                = 2,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int CNT_W                  = 16
) (
    input  logic                                         clk,
    input  logic                                         resetn,
    input  logic                                         start,
    input  logic [CNT_W-1:0]                             num_vectors,
    output logic                                         busy,
    output logic                                         done,
    gemm_stream_controller_if.slave                      bus,
    output logic                                         sa_advance,
    output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] sa_inputs,
    input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] sa_outputs
);

    localparam int L = 2 * SA_SIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [L-1:0]       r_tag;
    logic [CNT_W-1:0]   r_sent;
    logic [CNT_W-1:0]   r_recv;
    logic [CNT_W-1:0]   r_n;

    logic               w_can_adv;
    logic               w_res_hs;
    logic               w_at_last;
    logic               w_adv;
    logic               w_in_ready;
    logic               w_tag_in;
    logic               w_load;
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] w_sa_in;

    // Head of the tag pipe says whether the array output is a real result.
    assign bus.res_valid = r_tag[L-1];
    assign bus.res_data  = sa_outputs;
    assign w_can_adv     = !r_tag[L-1] || bus.res_ready;
    assign w_res_hs      = r_tag[L-1] && bus.res_ready;
    assign w_at_last     = (r_recv == r_n - CNT_W'(1));
    assign bus.res_last  = r_tag[L-1] && w_at_last;
    assign w_load        = (r_state == S_IDLE) && start && (num_vectors != '0);

    assign bus.in_ready  = w_in_ready;
    assign sa_advance    = w_adv;
    assign sa_inputs     = w_sa_in;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_adv       = 1'b0;
        w_sa_in     = '0;
        w_tag_in    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_vectors != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                busy       = 1'b1;
                w_in_ready = w_can_adv && (r_sent < r_n);
                w_adv      = bus.in_valid && w_in_ready;
                w_sa_in    = bus.in_data;
                w_tag_in   = 1'b1;
                if (w_res_hs && w_at_last) begin
                    w_state_nxt = S_DONE;
                end else if (w_adv && (r_sent + CNT_W'(1) == r_n)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy  = 1'b1;
                // flush zeros only while real vectors sit behind the head
                w_adv = w_can_adv && (|r_tag[L-2:0]);
                if (w_res_hs && w_at_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tag  <= '0;
            r_sent <= '0;
            r_recv <= '0;
            r_n    <= '0;
        end else begin
            if (w_load) begin
                r_n    <= num_vectors;
                r_sent <= '0;
                r_recv <= '0;
            end else begin
                if (w_adv && (r_state == S_RUN)) begin
                    r_sent <= r_sent + CNT_W'(1);
                end
                if (w_res_hs) begin
                    r_recv <= r_recv + CNT_W'(1);
                end
            end
            // A consumed head with no advance must not be seen again.
            if (w_adv) begin
                r_tag <= {r_tag[L-2:0], w_tag_in};
            end else if (w_res_hs) begin
                r_tag[L-1] <= 1'b0;
            end
        end
    end

endmodule

// File: doc/gemm_stream_controller.md
# gemm_stream_controller

Sequencer for the fixed-weight systolic array (`SA_SIZE`×`SA_SIZE`, weights already resident). It accepts a job of N activation vectors over a valid/ready stream and drives the array's advance strobe and activation inputs. It tracks which array outputs are real results and which are pipeline bubbles, flushes the pipeline with zero vectors at job end, and returns results over a valid/ready stream with back-pressure. It sits between the activation DMA/feeder and the array.

## Interface
Parameters:
- `SA_SIZE`, 2, array dimension; pipeline depth `L = 2*SA_SIZE` advances.
- `WEIGHT_ACTIVATION_SIZE`, 8, element width W.
- `CNT_W`, 16, width of the vector counters.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset; shared with the array.
- `start`  in  1  job start pulse; sampled only in IDLE.
- `num_vectors`  in  CNT_W  vectors in the job; sampled with `start`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at job completion.
- `in_valid`  in  1  activation vector valid.
- `in_ready`  out  1  controller accepts `in_data` this cycle.
- `in_data`  in  SA_SIZE×W  activation vector, element j at `[j]`.
- `res_valid`  out  1  result vector valid.
- `res_ready`  in  1  downstream accepts result.
- `res_data`  out  SA_SIZE×W  result, straight from `sa_outputs`.
- `res_last`  out  1  qualifies the final result of the job.
- `sa_advance`  out  1  drives the array's `should_advance_computation`.
- `sa_inputs`  out  SA_SIZE×W  drives the array's activation inputs.
- `sa_outputs`  in  SA_SIZE×W  array activation outputs; change only on advance.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start` with `num_vectors` > 0 → RUN; latch N, clear `sent` and `recv`.
  - `start` with `num_vectors` == 0 → DONE; no advance is issued.
- `start` outside IDLE is ignored.
- Tag shift register `tag[L-1:0]` shifts by one only on `sa_advance`; `tag[0]` gets 1 for a real vector, 0 for a bubble. `res_valid = tag[L-1]`.
- `can_adv = !res_valid || res_ready`: an advance never destroys an unconsumed result. The result handshake and an advance may occur in the same cycle.
- RUN:
  - `in_ready = can_adv && (sent < N)`.
  - `sa_advance = in_valid && in_ready`.
  - `sa_inputs = in_data`; each advance increments `sent`.
  - No bubbles are inserted while waiting for input.
  - When `sent` reaches N → DRAIN.
- DRAIN:
  - `in_ready = 0`; `sa_inputs = 0`.
  - `sa_advance = can_adv && |tag[L-2:0]`: advance only while real vectors remain behind the head.
- Every result handshake increments `recv`.
- `res_last = res_valid && (recv == N-1)`.
- Result handshake with `recv == N-1` → DONE, from either RUN or DRAIN.
- DONE: `done = 1` for one cycle, then IDLE. The tag register is all-zero at this point.
- In IDLE and DONE, `sa_advance = 0`, `sa_inputs = 0`, `in_ready = 0`.
- Wrap: counters are CNT_W bits; N ≤ 2^CNT_W − 1. No wrap within a job.

## Timing
- Reset values (asynchronous, while `resetn` = 0):
  - FSM = IDLE; `tag` = 0; `sent` = `recv` = 0; N = 0.
  - Every output is 0: `busy`, `done`, `in_ready`, `res_valid`, `res_last`, `sa_advance`, `sa_inputs`. `res_data` mirrors `sa_outputs`.
- Reset mid-job aborts the job, discards in-flight tags and issues no `done`. The array resets with it.
- `in_ready`, `sa_advance`, `sa_inputs`, `res_last` are combinational from state, `res_ready` and `in_valid`. `res_valid` is a flop.
- Latency: a vector accepted at cycle t appears as a result at cycle t+L, given an advance each of cycles t+1..t+L-1.
- Throughput: one vector per cycle with `in_valid` and `res_ready` held high.
- Back-pressure: with `res_valid` = 1 and `res_ready` = 0, `sa_advance` = 0 and `in_ready` = 0. `res_data` is held stable.
- First `busy` cycle is the cycle after `start`. `done` asserts the cycle after the final result handshake.

## Test plan
- Use array weights [[3,0],[0,2]] and SA_SIZE=2. Send N=1, input (2,5), `res_ready` held high. Required: `res_valid` 4 cycles after acceptance, `res_data` = (6,10), `res_last` = 1, `done` one cycle later, exactly 4 advances total.
- Same weights, N=2, inputs (2,5),(3,2) back-to-back. Required: results (6,10) then (9,4) on consecutive cycles, `res_last` only on the second, 5 advances total.
- N=2, `res_ready` = 0 for 10 cycles once the first result is valid. Required: `res_valid` and `res_data` = (6,10) stable, `sa_advance` = 0 throughout. After release, (9,4) follows.
- N=3 with `in_valid` gaps of 3 cycles. Required: no advance during gaps, results in order, `done` once.
- `start` with `num_vectors` = 0. Required: `done` pulse the next cycle, `busy` never high, no advance.
- Assert `resetn` low mid-DRAIN with 2 results pending. Required: all outputs 0 immediately. A fresh N=1 job then produces a correct single result.
